// File: rtl/csr_counter_if.sv
// CSR request/response bus between the EX-stage CSR datapath and csr_counter_ctrl.
//   master : requester (EX stage) - drives req_valid/req_func3/req_addr/req_wdata
//   slave  : csr_counter_ctrl     - drives req_ready/rsp_valid/rsp_rdata/rsp_illegal
interface csr_counter_if;
    localparam int unsigned FUNC_W = 3;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    logic              req_valid;
    logic              req_ready;
    logic [FUNC_W-1:0] req_func3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_illegal;

    modport master (
        output req_valid, req_func3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_illegal
    );

    modport slave (
        input  req_valid, req_func3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_illegal
    );
endinterface

// File: rtl/csr_counter_ctrl.sv
// csr_counter_ctrl: owns the 64-bit cycle/instret counters and sequences one CSR
// read-modify-write at a time against them (IDLE -> EXEC -> RESP).
//
// Ports:
//   clk, rst      core clock, asynchronous active-high reset
//   bus (slave)   req_valid/req_ready handshake, req_func3/req_addr/req_wdata,
//                 rsp_valid (one-cycle pulse), rsp_rdata (old value), rsp_illegal
//   retire        one instruction retired this cycle
//   cycle_o       live cycle counter
//   instret_o     live instret counter
//
// Optional feature macro: MCOUNTINHIBIT_EN adds mcountinhibit at 0x320
// (bit0 CY, bit2 IR). When undefined, 0x320 is illegal and counters always run.
module csr_counter_ctrl #(
    parameter int unsigned      CNT_W         = 64,
    parameter logic [CNT_W-1:0] RESET_CYCLE   = '0,
    parameter logic [CNT_W-1:0] RESET_INSTRET = '0
) (
    input  logic             clk,
    input  logic             rst,
    csr_counter_if.slave     bus,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_o,
    output logic [CNT_W-1:0] instret_o
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned FUNC_W = 3;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned ZIMM_W = 5;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [3:0] PAGE_M = 4'hB;   // machine counters, read-write
    localparam logic [3:0] PAGE_U = 4'hC;   // user shadows, read-only

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_illegal_q;

    logic [FUNC_W-1:0]   func3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [CNT_W-1:0]    cycle_q;
    logic [CNT_W-1:0]    instret_q;

    logic                accept_c;
    logic                exec_c;
    logic [DATA_W-1:0]   op_c;
    logic                ctr_hit_c;
    logic                ro_c;
    logic                sel_ins_c;
    logic                sel_hi_c;
    logic [CNT_W-1:0]    ctr_sel_c;
    logic [DATA_W-1:0]   old_c;
    logic [DATA_W-1:0]   new_c;
    logic                we_c;
    logic                illegal_c;
    logic                wr_c;
    logic                wr_cyc_c;
    logic                wr_ins_c;
    logic                inh_hit_c;
    logic                inh_cy;
    logic                inh_ir;
    logic [DATA_W-1:0]   inhibit_rd_c;

    assign accept_c = bus.req_valid && req_ready_q;
    assign exec_c   = (state_q == ST_EXEC);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Next state; ready/valid are registered so they track the state being entered
    always_comb begin
        state_d     = state_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_EXEC;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_EXEC: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // Capture request fields at the handshake so the requester is free afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            func3_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept_c) begin
            func3_q <= bus.req_func3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

`ifdef MCOUNTINHIBIT_EN
    localparam logic [ADDR_W-1:0] ADDR_MCOUNTINHIBIT = 12'h320;

    logic wr_inh_c;

    assign inh_hit_c = (addr_q == ADDR_MCOUNTINHIBIT);
    assign wr_inh_c  = wr_c && inh_hit_c;

    // mcountinhibit: only CY (bit0) and IR (bit2) are implemented
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inh_cy <= 1'b0;
            inh_ir <= 1'b0;
        end else if (wr_inh_c) begin
            inh_cy <= new_c[0];
            inh_ir <= new_c[2];
        end
    end
`else
    assign inh_hit_c = 1'b0;
    assign inh_cy    = 1'b0;
    assign inh_ir    = 1'b0;
`endif

    assign inhibit_rd_c = {{(DATA_W-3){1'b0}}, inh_ir, 1'b0, inh_cy};

    // Address decode, operand select and read-modify-write value
    always_comb begin
        op_c      = func3_q[2] ? DATA_W'(wdata_q[ZIMM_W-1:0]) : wdata_q;
        // Counter CSRs: page B/C, bit7 = high half, bit1 = instret, all other bits zero
        ctr_hit_c = ((addr_q[11:8] == PAGE_M) || (addr_q[11:8] == PAGE_U)) &&
                    (addr_q[6:2] == 5'd0) && !addr_q[0];
        ro_c      = (addr_q[11:8] == PAGE_U);
        sel_ins_c = addr_q[1];
        sel_hi_c  = addr_q[7];
        ctr_sel_c = sel_ins_c ? instret_q : cycle_q;

        old_c = '0;
        if (ctr_hit_c) begin
            old_c = sel_hi_c ? ctr_sel_c[CNT_W-1:DATA_W] : ctr_sel_c[DATA_W-1:0];
        end else if (inh_hit_c) begin
            old_c = inhibit_rd_c;
        end

        case (func3_q[1:0])
            OP_RW:   new_c = op_c;
            OP_RS:   new_c = old_c | op_c;
            OP_RC:   new_c = old_c & ~op_c;
            default: new_c = '0;
        endcase

        // Set/clear with a zero operand is a pure read
        we_c      = (func3_q[1:0] == OP_RW) || (op_c != '0);
        illegal_c = (func3_q[1:0] == 2'b00) || !(ctr_hit_c || inh_hit_c) ||
                    (we_c && ctr_hit_c && ro_c);
        wr_c      = exec_c && we_c && !illegal_c;
        wr_cyc_c  = wr_c && ctr_hit_c && !sel_ins_c;
        wr_ins_c  = wr_c && ctr_hit_c && sel_ins_c;
    end

    // Cycle counter: a software write replaces one half and suppresses that cycle's increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= RESET_CYCLE;
        end else if (wr_cyc_c) begin
            if (sel_hi_c) begin
                cycle_q[CNT_W-1:DATA_W] <= new_c;
            end else begin
                cycle_q[DATA_W-1:0] <= new_c;
            end
        end else if (!inh_cy) begin
            cycle_q <= cycle_q + CNT_W'(1);
        end
    end

    // Instret counter: a retire coinciding with a minstret write is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= RESET_INSTRET;
        end else if (wr_ins_c) begin
            if (sel_hi_c) begin
                instret_q[CNT_W-1:DATA_W] <= new_c;
            end else begin
                instret_q[DATA_W-1:0] <= new_c;
            end
        end else if (retire && !inh_ir) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Response payload, latched at the end of EXEC and presented during RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata_q   <= '0;
            rsp_illegal_q <= 1'b0;
        end else if (exec_c) begin
            rsp_rdata_q   <= illegal_c ? '0 : old_c;
            rsp_illegal_q <= illegal_c;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_illegal = rsp_illegal_q;
    assign cycle_o         = cycle_q;
    assign instret_o       = instret_q;

endmodule

// File: tb/tb_csr_counter_ctrl.sv
// Self-checking bench for csr_counter_ctrl: transaction-level counter model plus a
// response scoreboard (expected pushed during EXEC, popped when rsp_valid is seen).
module tb_csr_counter_ctrl;
    localparam int unsigned CNT_W = 64;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ill;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             retire;
    logic [CNT_W-1:0] cycle_o;
    logic [CNT_W-1:0] instret_o;

    csr_counter_if bus ();

    csr_counter_ctrl #(
        .CNT_W        (CNT_W),
        .RESET_CYCLE  (64'd0),
        .RESET_INSTRET(64'd0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .retire   (retire),
        .cycle_o  (cycle_o),
        .instret_o(instret_o)
    );

    int n_vec = 0;
    int n_err = 0;

    exp_t exp_q[$];
    exp_t mon_e;

    logic [63:0] exp_cyc;
    logic [63:0] exp_ins;
    logic [2:0]  exp_inh;
    logic        pend_wr;
    int          pend_tgt;
    logic        pend_hi;
    logic [31:0] pend_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour of one CSR access against the current model state
    function automatic void model_req(input logic [2:0] f, input logic [11:0] a,
                                      input logic [31:0] w, output exp_t e,
                                      output logic wr, output int tgt,
                                      output logic hi, output logic [31:0] nv);
        logic [31:0] op;
        logic [31:0] old;
        logic        mapped;
        logic        ro;
        logic        we;
        logic        ill;
        op     = f[2] ? {27'd0, w[4:0]} : w;
        mapped = 1'b1;
        ro     = 1'b0;
        tgt    = 0;
        hi     = 1'b0;
        case (a)
            12'hB00: begin tgt = 0; hi = 1'b0; end
            12'hB80: begin tgt = 0; hi = 1'b1; end
            12'hB02: begin tgt = 1; hi = 1'b0; end
            12'hB82: begin tgt = 1; hi = 1'b1; end
            12'hC00: begin tgt = 0; hi = 1'b0; ro = 1'b1; end
            12'hC80: begin tgt = 0; hi = 1'b1; ro = 1'b1; end
            12'hC02: begin tgt = 1; hi = 1'b0; ro = 1'b1; end
            12'hC82: begin tgt = 1; hi = 1'b1; ro = 1'b1; end
`ifdef MCOUNTINHIBIT_EN
            12'h320: begin tgt = 2; end
`endif
            default: mapped = 1'b0;
        endcase
        if (!mapped)      old = 32'd0;
        else if (tgt == 0) old = hi ? exp_cyc[63:32] : exp_cyc[31:0];
        else if (tgt == 1) old = hi ? exp_ins[63:32] : exp_ins[31:0];
        else              old = {29'd0, exp_inh};
        case (f[1:0])
            2'b01:   nv = op;
            2'b10:   nv = old | op;
            2'b11:   nv = old & ~op;
            default: nv = 32'd0;
        endcase
        we      = (f[1:0] == 2'b01) || (op != 32'd0);
        ill     = (f[1:0] == 2'b00) || !mapped || (we && ro);
        wr      = we && !ill;
        e.rdata = ill ? 32'd0 : old;
        e.ill   = ill;
    endfunction

    // Advance one clock and update the counter model for that edge
    task automatic cyc();
        logic [63:0] nc;
        logic [63:0] ni;
        @(posedge clk);
        if (rst) begin
            exp_cyc = 64'd0;
            exp_ins = 64'd0;
            exp_inh = 3'd0;
            pend_wr = 1'b0;
        end else begin
            nc = exp_inh[0] ? exp_cyc : exp_cyc + 64'd1;
            ni = (retire && !exp_inh[2]) ? exp_ins + 64'd1 : exp_ins;
            if (pend_wr) begin
                case (pend_tgt)
                    0: nc = pend_hi ? {pend_val, exp_cyc[31:0]} : {exp_cyc[63:32], pend_val};
                    1: ni = pend_hi ? {pend_val, exp_ins[31:0]} : {exp_ins[63:32], pend_val};
                    default: exp_inh = pend_val[2:0] & 3'b101;
                endcase
            end
            exp_cyc = nc;
            exp_ins = ni;
            pend_wr = 1'b0;
        end
        @(negedge clk);
    endtask

    // One complete access: accept, EXEC (optional retire), RESP
    task automatic do_req(input logic [2:0] f, input logic [11:0] a,
                          input logic [31:0] w, input logic ret_exec);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_func3 = f;
        bus.req_addr  = a;
        bus.req_wdata = w;
        retire        = 1'b0;
        n_vec++;
        if (bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL req_ready_idle: got %b expected 1", bus.req_ready);
        end
        cyc();
        bus.req_valid = 1'b0;
        bus.req_func3 = 3'($urandom);
        bus.req_addr  = 12'($urandom);
        bus.req_wdata = $urandom;
        retire        = ret_exec;
        model_req(f, a, w, e, pend_wr, pend_tgt, pend_hi, pend_val);
        exp_q.push_back(e);
        n_vec++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL exec_flags: got ready=%b valid=%b expected 0/0",
                     bus.req_ready, bus.rsp_valid);
        end
        cyc();
        retire = 1'b0;
        n_vec++;
        if (bus.rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rsp_latency a=%h: got rsp_valid=%b expected 1", a, bus.rsp_valid);
        end
        cyc();
    endtask

    // Scoreboard: every response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got rdata=%h ill=%b expected no response",
                         bus.rsp_rdata, bus.rsp_illegal);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rsp_rdata !== mon_e.rdata || bus.rsp_illegal !== mon_e.ill) begin
                    n_err++;
                    $display("FAIL rsp_data: got rdata=%h ill=%b expected rdata=%h ill=%b",
                             bus.rsp_rdata, bus.rsp_illegal, mon_e.rdata, mon_e.ill);
                end
            end
        end
    end

    task automatic test_reset();
        rst           = 1'b1;
        retire        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_func3 = 3'd0;
        bus.req_addr  = 12'd0;
        bus.req_wdata = 32'd0;
        exp_cyc = 64'd0; exp_ins = 64'd0; exp_inh = 3'd0; pend_wr = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hs: got ready=%b valid=%b expected 1/0", bus.req_ready, bus.rsp_valid);
        end
        n_vec++;
        if (bus.rsp_rdata !== 32'd0 || bus.rsp_illegal !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rsp: got rdata=%h ill=%b expected 0/0", bus.rsp_rdata, bus.rsp_illegal);
        end
        n_vec++;
        if (cycle_o !== 64'd0 || instret_o !== 64'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got cycle=%h instret=%h expected 0/0", cycle_o, instret_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_cycle_read();
        repeat (10) cyc();
        n_vec++;
        if (cycle_o !== 64'd10) begin
            n_err++;
            $display("FAIL cycle_idle10: got %0d expected 10", cycle_o);
        end
        do_req(3'b010, 12'hC00, 32'd0, 1'b0);
        do_req(3'b010, 12'hC80, 32'd0, 1'b0);
        n_vec++;
        if (cycle_o !== exp_cyc) begin
            n_err++;
            $display("FAIL cycle_run: got %h expected %h", cycle_o, exp_cyc);
        end
    endtask

    task automatic test_instret();
        repeat (5) begin
            retire = 1'b1;
            cyc();
        end
        retire = 1'b0;
        n_vec++;
        if (instret_o !== 64'd5) begin
            n_err++;
            $display("FAIL instret_5: got %0d expected 5", instret_o);
        end
        do_req(3'b010, 12'hC02, 32'd0, 1'b1);
        n_vec++;
        if (instret_o !== 64'd6) begin
            n_err++;
            $display("FAIL instret_exec_retire: got %0d expected 6", instret_o);
        end
        do_req(3'b110, 12'hC82, 32'd0, 1'b0);
    endtask

    task automatic test_preload();
        do_req(3'b001, 12'hB80, 32'd0, 1'b0);
        do_req(3'b001, 12'hB00, 32'hFFFF_FFFE, 1'b0);
        cyc();
        n_vec++;
        if (cycle_o !== 64'h0000_0001_0000_0000 || cycle_o !== exp_cyc) begin
            n_err++;
            $display("FAIL cycle_carry: got %h expected %h", cycle_o, 64'h0000_0001_0000_0000);
        end
        do_req(3'b001, 12'hB80, 32'hFFFF_FFFF, 1'b0);
        do_req(3'b001, 12'hB00, 32'hFFFF_FFFE, 1'b0);
        cyc();
        n_vec++;
        if (cycle_o !== 64'd0) begin
            n_err++;
            $display("FAIL cycle_wrap: got %h expected 0", cycle_o);
        end
        do_req(3'b001, 12'hB82, 32'hFFFF_FFFF, 1'b0);
        do_req(3'b001, 12'hB02, 32'hFFFF_FFFF, 1'b0);
        retire = 1'b1;
        cyc();
        retire = 1'b0;
        n_vec++;
        if (instret_o !== 64'd0) begin
            n_err++;
            $display("FAIL instret_wrap: got %h expected 0", instret_o);
        end
    endtask

    task automatic test_write_priority();
        do_req(3'b001, 12'hB02, 32'h0000_0100, 1'b1);
        n_vec++;
        if (instret_o[31:0] !== 32'h0000_0100 || instret_o !== exp_ins) begin
            n_err++;
            $display("FAIL minstret_wr_retire: got %h expected low 00000100", instret_o);
        end
        do_req(3'b110, 12'hB02, 32'hFFFF_FFE3, 1'b1);
        do_req(3'b011, 12'hB02, 32'h0000_0001, 1'b0);
        do_req(3'b111, 12'hB02, 32'd0, 1'b1);
        do_req(3'b010, 12'hB02, 32'd0, 1'b0);
        n_vec++;
        if (instret_o !== exp_ins) begin
            n_err++;
            $display("FAIL minstret_rmw: got %h expected %h", instret_o, exp_ins);
        end
        do_req(3'b001, 12'hB80, 32'h0000_00A5, 1'b1);
        n_vec++;
        if (cycle_o !== exp_cyc || instret_o !== exp_ins) begin
            n_err++;
            $display("FAIL mcycleh_wr: got %h/%h expected %h/%h", cycle_o, instret_o, exp_cyc, exp_ins);
        end
    endtask

    task automatic test_illegal();
        logic [2:0]  fv [10];
        logic [11:0] av [10];
        logic [31:0] wv [10];
        fv = '{3'b001, 3'b100, 3'b001, 3'b000, 3'b010, 3'b110, 3'b001, 3'b001, 3'b011, 3'b101};
        av = '{12'hC00, 12'hB00, 12'h7C0, 12'hC02, 12'hC00, 12'hC80, 12'h320, 12'hB01, 12'hC82, 12'hC02};
        wv = '{32'd1, 32'd5, 32'd0, 32'd0, 32'd3, 32'hFFFF_FFE0, 32'd7, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 10; i++) begin
            do_req(fv[i], av[i], wv[i], 1'(i % 2));
        end
        n_vec++;
        if (cycle_o !== exp_cyc || instret_o !== exp_ins) begin
            n_err++;
            $display("FAIL illegal_no_write: got %h/%h expected %h/%h", cycle_o, instret_o, exp_cyc, exp_ins);
        end
    endtask

    task automatic test_inhibit();
`ifdef MCOUNTINHIBIT_EN
        logic [63:0] frz_c;
        logic [63:0] frz_i;
        do_req(3'b110, 12'h320, 32'd5, 1'b0);
        frz_c = exp_cyc;
        frz_i = exp_ins;
        retire = 1'b1;
        repeat (3) cyc();
        retire = 1'b0;
        n_vec++;
        if (cycle_o !== frz_c || instret_o !== frz_i) begin
            n_err++;
            $display("FAIL inhibit_freeze: got %h/%h expected %h/%h", cycle_o, instret_o, frz_c, frz_i);
        end
        do_req(3'b010, 12'h320, 32'd0, 1'b0);
        do_req(3'b001, 12'hB00, 32'h0000_1234, 1'b0);
        n_vec++;
        if (cycle_o[31:0] !== 32'h0000_1234) begin
            n_err++;
            $display("FAIL inhibit_write: got %h expected 00001234", cycle_o[31:0]);
        end
        do_req(3'b111, 12'h320, 32'd1, 1'b0);
        frz_i = exp_ins;
        retire = 1'b1;
        repeat (2) cyc();
        retire = 1'b0;
        n_vec++;
        if (cycle_o !== exp_cyc || cycle_o[31:0] === 32'h0000_1234 || instret_o !== frz_i) begin
            n_err++;
            $display("FAIL inhibit_resume: got %h/%h expected %h/%h", cycle_o, instret_o, exp_cyc, frz_i);
        end
        do_req(3'b001, 12'h320, 32'hFFFF_FFFF, 1'b0);
        do_req(3'b001, 12'h320, 32'd0, 1'b0);
`else
        do_req(3'b110, 12'h320, 32'd5, 1'b0);
        retire = 1'b1;
        repeat (2) cyc();
        retire = 1'b0;
        n_vec++;
        if (cycle_o !== exp_cyc || instret_o !== exp_ins) begin
            n_err++;
            $display("FAIL no_inhibit: got %h/%h expected %h/%h", cycle_o, instret_o, exp_cyc, exp_ins);
        end
`endif
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_func3 = 3'b010;
        bus.req_addr  = 12'hC00;
        bus.req_wdata = 32'd0;
        cyc();
        model_req(3'b010, 12'hC00, 32'd0, e, pend_wr, pend_tgt, pend_hi, pend_val);
        exp_q.push_back(e);
        bus.req_func3 = 3'b001;
        bus.req_addr  = 12'hB82;
        bus.req_wdata = 32'h0000_0007;
        n_vec++;
        if (bus.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_exec_ready: got %b expected 0", bus.req_ready);
        end
        cyc();
        n_vec++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_resp: got ready=%b valid=%b expected 0/1", bus.req_ready, bus.rsp_valid);
        end
        cyc();
        n_vec++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: got ready=%b valid=%b expected 1/0", bus.req_ready, bus.rsp_valid);
        end
        cyc();
        bus.req_valid = 1'b0;
        retire        = 1'b1;
        model_req(3'b001, 12'hB82, 32'h0000_0007, e, pend_wr, pend_tgt, pend_hi, pend_val);
        exp_q.push_back(e);
        cyc();
        retire = 1'b0;
        n_vec++;
        if (bus.rsp_valid !== 1'b1 || instret_o !== exp_ins) begin
            n_err++;
            $display("FAIL b2b_second: got valid=%b instret=%h expected 1/%h", bus.rsp_valid, instret_o, exp_ins);
        end
        cyc();
    endtask

    task automatic test_reset_abort();
        bus.req_valid = 1'b1;
        bus.req_func3 = 3'b001;
        bus.req_addr  = 12'hB00;
        bus.req_wdata = 32'h0000_DEAD;
        cyc();
        bus.req_valid = 1'b0;
        rst = 1'b1;
        exp_cyc = 64'd0; exp_ins = 64'd0; exp_inh = 3'd0; pend_wr = 1'b0;
        #1;
        n_vec++;
        if (cycle_o !== 64'd0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got cycle=%h ready=%b valid=%b expected 0/1/0",
                     cycle_o, bus.req_ready, bus.rsp_valid);
        end
        cyc();
        rst = 1'b0;
        repeat (4) cyc();
        n_vec++;
        if (cycle_o !== exp_cyc || cycle_o !== 64'd4) begin
            n_err++;
            $display("FAIL abort_no_write: got %h expected 4", cycle_o);
        end
    endtask

    initial begin
        test_reset();
        test_cycle_read();
        test_instret();
        test_preload();
        test_write_priority();
        test_illegal();
        test_inhibit();
        test_back_to_back();
        test_reset_abort();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rsp_missing: got %0d outstanding expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
